piso_tx: RTL and testbench

Parallel-in serial-out transmitter. It is the sending end of the team's parallel word-register path: it accepts an N-bit word through a load/ready handshake, then shifts the word out on a single line. Each frame is one start bit, N data bits LSB first, an optional parity bit, and one stop bit. It drives the serial link whose far end deserializes back into a parallel-load register.

---
 rtl/piso_tx_pkg.sv | 16 +
 rtl/piso_tx_if.sv | 30 +++
 rtl/piso_tx_bit_timer.sv | 31 +++
 rtl/piso_tx.sv | 135 +++++++++++++
 tb/tb_piso_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/piso_tx_pkg.sv
// Shared state encoding and serial line levels for the piso_tx transmitter.
package piso_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/piso_tx_if.sv
// Load/ready handshake plus serial line and status for piso_tx.
// The producer side uses the master modport, the transmitter uses slave.
interface piso_tx_if #(
    parameter int N = 4
);
    logic         i_load;
    logic [N-1:0] i_parallel_in;
    logic         o_ready;
    logic         o_serial_out;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_load,
        output i_parallel_in,
        input  o_ready,
        input  o_serial_out,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_load,
        input  i_parallel_in,
        output o_ready,
        output o_serial_out,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/piso_tx_bit_timer.sv
// Counts clock cycles within one serial bit; bit_tick marks the last cycle of
// the bit and pre_tick the cycle before it (only when bits span >1 cycle).
module piso_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic run,
    output logic bit_tick,
    output logic pre_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= bit_tick ? '0 : count + CW'(1);
        end
    end

    assign bit_tick = run && (count == LAST_CNT);
    // Lets the owner register a flag that lands exactly on the last cycle.
    assign pre_tick = (CLKS_PER_BIT > 1) && run && (count == PRE_CNT);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, N data bits LSB first,
// optional even parity (enabled by PISO_TX_PARITY_EN), one stop bit.
module piso_tx
    import piso_pkg::*;
#(
    parameter int N            = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input logic       i_clk,
    input logic       i_rst,
    piso_tx_if.slave  bus
);
    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic SINGLE_CYCLE_BIT = (CLKS_PER_BIT == 1);

    state_t        state;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  shift_next;
    logic [IW-1:0] bit_idx;
    logic          ready;
    logic          serial;
    logic          busy;
    logic          done;
    logic          accept;
    logic          bit_tick;
    logic          pre_tick;
`ifdef PISO_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign accept     = (state == IDLE) && bus.i_load;
    assign shift_next = shift_reg >> 1;

    piso_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .clear    (accept),
        .run      (busy),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    // Every output is set one edge ahead so the line changes right at bit boundaries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            ready      <= 1'b1;
            serial     <= IDLE_LINE;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= bus.i_parallel_in;
`ifdef PISO_TX_PARITY_EN
                        parity_bit <= ^bus.i_parallel_in;
`endif
                        bit_idx    <= '0;
                        state      <= START;
                        serial     <= START_BIT;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state  <= DATA;
                        serial <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= shift_next;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
`ifdef PISO_TX_PARITY_EN
                            state   <= PARITY;
                            serial  <= parity_bit;
`else
                            state   <= STOP;
                            serial  <= STOP_BIT;
                            done    <= SINGLE_CYCLE_BIT;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            serial  <= shift_next[0];
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state  <= STOP;
                        serial <= STOP_BIT;
                        done   <= SINGLE_CYCLE_BIT;
                    end
                end
`endif
                STOP: begin
                    if (pre_tick) begin
                        done <= 1'b1;
                    end
                    if (bit_tick) begin
                        state  <= IDLE;
                        serial <= IDLE_LINE;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    serial <= IDLE_LINE;
                    ready  <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_serial_out = serial;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a fast instance (1 clock per bit) and a slow
// one (3 clocks per bit); frame tables follow PISO_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_piso_tx;
    localparam int N = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FBITS = N + 2 + P;

    typedef struct {
        logic [N-1:0] word;
        logic [7:0]   frame;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.N(N)) fast_bus ();
    piso_tx_if #(.N(N)) slow_bus ();

    piso_tx #(.N(N), .CLKS_PER_BIT(1)) dut_fast (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (fast_bus.slave)
    );

    piso_tx #(.N(N), .CLKS_PER_BIT(3)) dut_slow (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (slow_bus.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sampleOut(input bit slow, output logic line, output logic rdy, output logic bsy, output logic dn);
        line = slow ? slow_bus.o_serial_out : fast_bus.o_serial_out;
        rdy  = slow ? slow_bus.o_ready      : fast_bus.o_ready;
        bsy  = slow ? slow_bus.o_busy       : fast_bus.o_busy;
        dn   = slow ? slow_bus.o_done       : fast_bus.o_done;
    endtask

    // Returns at the negedge of cycle 1 (the first cycle after the accept edge).
    task automatic applyStimulus(input bit slow, input logic [N-1:0] word, input bit hold);
        logic line, rdy, bsy, dn;
        int waited = 0;
        do begin
            @(negedge clk);
            sampleOut(slow, line, rdy, bsy, dn);
            waited++;
        end while (!rdy && waited < 50);
        checkOutput("ready before load", rdy, 1'b1);
        if (slow) begin
            slow_bus.i_load = 1'b1;
            slow_bus.i_parallel_in = word;
        end else begin
            fast_bus.i_load = 1'b1;
            fast_bus.i_parallel_in = word;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            slow_bus.i_load = 1'b0;
            fast_bus.i_load = 1'b0;
        end
    endtask

    // Checks cycles 1..F of a frame, then the idle cycle F+1; leaves the bench at F+1.
    task automatic checkFrame(input bit slow, input string tag, input logic [7:0] exp_bits,
                              input int clks, input bit inject);
        logic line, rdy, bsy, dn;
        int flen;
        flen = FBITS * clks;
        for (int k = 0; k < flen; k++) begin
            if (k > 0) @(negedge clk);
            if (inject && k == 1) begin
                fast_bus.i_load = 1'b1;
                fast_bus.i_parallel_in = '1;
            end
            if (inject && k == 5) fast_bus.i_load = 1'b0;
            sampleOut(slow, line, rdy, bsy, dn);
            checkOutput($sformatf("%s line cycle %0d", tag, k + 1), line, exp_bits[k / clks]);
            checkOutput($sformatf("%s done cycle %0d", tag, k + 1), dn, (k == flen - 1));
            if (k == 0) begin
                checkOutput($sformatf("%s busy cycle 1", tag), bsy, 1'b1);
                checkOutput($sformatf("%s ready cycle 1", tag), rdy, 1'b0);
            end
        end
        @(negedge clk);
        sampleOut(slow, line, rdy, bsy, dn);
        checkOutput($sformatf("%s ready after frame", tag), rdy, 1'b1);
        checkOutput($sformatf("%s busy after frame", tag), bsy, 1'b0);
        checkOutput($sformatf("%s done after frame", tag), dn, 1'b0);
        checkOutput($sformatf("%s line after frame", tag), line, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        logic [7:0] frame_0101;
        logic [7:0] frame_0111;
        logic line, rdy, bsy, dn;

`ifdef PISO_TX_PARITY_EN
        vecs[0] = '{4'b1010, 8'b01010100};
        vecs[1] = '{4'b0111, 8'b01101110};
        vecs[2] = '{4'b0000, 8'b01000000};
        vecs[3] = '{4'b1111, 8'b01011110};
        vecs[4] = '{4'b0001, 8'b01100010};
        vecs[5] = '{4'b1000, 8'b01110000};
        frame_0101 = 8'b01001010;
`else
        vecs[0] = '{4'b1010, 8'b00110100};
        vecs[1] = '{4'b0111, 8'b00101110};
        vecs[2] = '{4'b0000, 8'b00100000};
        vecs[3] = '{4'b1111, 8'b00111110};
        vecs[4] = '{4'b0001, 8'b00100010};
        vecs[5] = '{4'b1000, 8'b00110000};
        frame_0101 = 8'b00101010;
`endif
        frame_0111 = vecs[1].frame;

        // Reset held with a pending load: reset must win.
        fast_bus.i_load = 1'b1;
        fast_bus.i_parallel_in = '1;
        slow_bus.i_load = 1'b0;
        slow_bus.i_parallel_in = '0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sampleOut(1'b0, line, rdy, bsy, dn);
            checkOutput($sformatf("reset line %0d", c), line, 1'b1);
            checkOutput($sformatf("reset ready %0d", c), rdy, 1'b1);
            checkOutput($sformatf("reset busy %0d", c), bsy, 1'b0);
            checkOutput($sformatf("reset done %0d", c), dn, 1'b0);
        end
        rst = 1'b0;
        fast_bus.i_load = 1'b0;
        @(negedge clk);
        sampleOut(1'b0, line, rdy, bsy, dn);
        checkOutput("post-reset no accept line", line, 1'b1);
        checkOutput("post-reset no accept ready", rdy, 1'b1);

        $display("[TB] table-driven frames");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, vecs[i].word, 1'b0);
            checkFrame(1'b0, $sformatf("vec%0d", i), vecs[i].frame, 1, 1'b0);
        end

        $display("[TB] load ignored while busy");
        applyStimulus(1'b0, 4'b0101, 1'b0);
        checkFrame(1'b0, "ignored", frame_0101, 1, 1'b1);
        @(negedge clk);
        sampleOut(1'b0, line, rdy, bsy, dn);
        checkOutput("ignored word not sent line", line, 1'b1);
        checkOutput("ignored word not sent busy", bsy, 1'b0);

        $display("[TB] back-to-back frames");
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkFrame(1'b0, "b2b first", vecs[5].frame, 1, 1'b0);
        fast_bus.i_parallel_in = 4'b0111;
        @(negedge clk);
        fast_bus.i_load = 1'b0;
        checkFrame(1'b0, "b2b second", frame_0111, 1, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 4'b1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sampleOut(1'b0, line, rdy, bsy, dn);
        checkOutput("midreset line", line, 1'b1);
        checkOutput("midreset ready", rdy, 1'b1);
        checkOutput("midreset busy", bsy, 1'b0);
        checkOutput("midreset done", dn, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sampleOut(1'b0, line, rdy, bsy, dn);
            checkOutput($sformatf("midreset quiet done %0d", c), dn, 1'b0);
            checkOutput($sformatf("midreset quiet line %0d", c), line, 1'b1);
        end
        applyStimulus(1'b0, 4'b1010, 1'b0);
        checkFrame(1'b0, "after midreset", vecs[0].frame, 1, 1'b0);

        $display("[TB] slow bits");
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkFrame(1'b1, "slow", vecs[4].frame, 3, 1'b0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
